// File: rtl/score_text_renderer.sv
// rtl/score_text_renderer.sv - binary score to BCD digits, rendered over the VGA raster via a font ROM
module score_text_renderer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 14,
    parameter int ORIGIN_X   = 16,
    parameter int ORIGIN_Y   = 16,
    parameter int LEAD_BLANK = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    input  logic [9:0]         h_count,
    input  logic [9:0]         v_count,
    input  logic               video_on,
    output logic [7:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pixel_on
);
    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int MAX_VAL = 10 ** NUM_DIGITS - 1;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic signed [10:0] BOX_W = 11'(8 * NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t             state;
    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W-1:0] pend_score;
    logic               pend_valid;
    logic [SCORE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   shown;
    logic [SCORE_W-1:0] clamped;

    logic signed [10:0] h_rel;
    logic signed [10:0] v_rel;
    logic               in_band_v;
    logic               in_box;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         col;
    logic [3:0]         row;
    logic [3:0]         cur_digit;
    logic [3:0]         dig;
    logic               lead_zero;
    logic               blank;

    logic               in_box_d1, in_box_d2;
    logic               video_d1, video_d2;
    logic               blank_d1, blank_d2;
    logic [2:0]         col_d1, col_d2;

    always_comb begin
        clamped = (32'(cur_score) > 32'(MAX_VAL)) ? SCORE_W'(MAX_VAL) : cur_score;
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // Signed 11-bit offsets so columns/rows left of or above the origin never wrap into the box
    assign h_rel     = {1'b0, h_count} - 11'(ORIGIN_X);
    assign v_rel     = {1'b0, v_count} - 11'(ORIGIN_Y);
    assign in_band_v = (v_rel >= 11'sd0) && (v_rel < 11'sd16);
    assign in_box    = in_band_v && (h_rel >= 11'sd0) && (h_rel < BOX_W);
    assign idx       = h_rel[IDX_W+2:3];
    assign col       = h_rel[2:0];
    assign row       = v_rel[3:0];

    // Digit 0 is the most significant; lead_zero tracks whether all digits left of i are zero
    always_comb begin
        cur_digit = 4'd0;
        dig       = 4'd0;
        lead_zero = 1'b1;
        blank     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = shown[4*(NUM_DIGITS-1-i) +: 4];
            if (IDX_W'(i) == idx) begin
                cur_digit = dig;
                blank     = (LEAD_BLANK != 0) && lead_zero && (dig == 4'd0) && (i != NUM_DIGITS - 1);
            end
            if (dig != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cur_score  <= '0;
            pend_score <= '0;
            pend_valid <= 1'b0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            cnt        <= '0;
            shown      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        cur_score <= score;
                        state     <= LOAD;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    bin_sr <= clamped;
                    bcd_sr <= '0;
                    cnt    <= CNT_W'(SCORE_W);
                    state  <= SHIFT;
                end
                SHIFT: begin
                    bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // Hold the result while the raster is inside the text band to avoid a torn frame
                    if (!in_band_v) begin
                        shown <= bcd_sr;
                        if (pend_valid || score_valid) begin
                            cur_score <= score_valid ? score : pend_score;
                            state     <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && score_valid) begin
                pend_score <= score;
                pend_valid <= 1'b1;
            end
            if (state == COMMIT && !in_band_v && (pend_valid || score_valid)) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= 8'd0;
            in_box_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
            video_d1  <= 1'b0;
            video_d2  <= 1'b0;
            blank_d1  <= 1'b0;
            blank_d2  <= 1'b0;
            col_d1    <= 3'd0;
            col_d2    <= 3'd0;
            pixel_on  <= 1'b0;
        end else begin
            if (in_box) begin
                rom_addr <= {cur_digit, row};
            end
            in_box_d1 <= in_box;
            video_d1  <= video_on;
            blank_d1  <= blank;
            col_d1    <= col;
            in_box_d2 <= in_box_d1;
            video_d2  <= video_d1;
            blank_d2  <= blank_d1;
            col_d2    <= col_d1;
            pixel_on  <= in_box_d2 & video_d2 & ~blank_d2 & rom_data[3'd7 - col_d2];
        end
    end
endmodule
